// File: rtl/rvfi_commit_packer.sv
// Registers one retirement record per cycle onto the RVFI signal set: assigns order, scrubs
// don't-care fields, latches halt, and runs marker-delimited segment counters for IPC readout.
module rvfi_commit_packer #(
   parameter int ORDER_W = 64,
   parameter int CNT_W   = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               commit_valid,
   input  logic [31:0]        commit_inst,
   input  logic [31:0]        commit_pc,
   input  logic [31:0]        commit_pc_next,
   input  logic [4:0]         commit_rs1_addr,
   input  logic [4:0]         commit_rs2_addr,
   input  logic [4:0]         commit_rd_addr,
   input  logic [31:0]        commit_rs1_rdata,
   input  logic [31:0]        commit_rs2_rdata,
   input  logic [31:0]        commit_rd_wdata,
   input  logic [31:0]        commit_mem_addr,
   input  logic [31:0]        commit_mem_rdata,
   input  logic [31:0]        commit_mem_wdata,
   input  logic [3:0]         commit_mem_rmask,
   input  logic [3:0]         commit_mem_wmask,
   output logic               rvfi_valid,
   output logic [ORDER_W-1:0] rvfi_order,
   output logic [31:0]        rvfi_inst,
   output logic [31:0]        rvfi_pc_rdata,
   output logic [31:0]        rvfi_pc_wdata,
   output logic [4:0]         rvfi_rs1_addr,
   output logic [4:0]         rvfi_rs2_addr,
   output logic [4:0]         rvfi_rd_addr,
   output logic [31:0]        rvfi_rs1_rdata,
   output logic [31:0]        rvfi_rs2_rdata,
   output logic [31:0]        rvfi_rd_wdata,
   output logic [31:0]        rvfi_mem_addr,
   output logic [31:0]        rvfi_mem_rdata,
   output logic [31:0]        rvfi_mem_wdata,
   output logic [3:0]         rvfi_mem_rmask,
   output logic [3:0]         rvfi_mem_wmask,
   output logic               rvfi_halt,
   output logic [CNT_W-1:0]   seg_cycles,
   output logic [CNT_W-1:0]   seg_insts,
   output logic               seg_active,
   output logic               seg_done
);

   localparam logic [31:0]        START_INST = 32'h0010_2013;
   localparam logic [31:0]        STOP_INST  = 32'h0020_2013;
   localparam logic [ORDER_W-1:0] ORD_ONE    = {{(ORDER_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} seg_state_t;

   seg_state_t         r_state, w_state_nxt;
   logic [ORDER_W-1:0] r_order;
   logic               r_halt, r_halt_pend;
   logic [CNT_W-1:0]   r_cyc, r_ins, w_cyc_nxt, w_ins_nxt;
   logic               w_accept, w_is_halt, w_mem_any;
   logic [31:0]        w_rbyte, w_wbyte;

   // The record accepted in the halt cycle blocks the next commit even though rvfi_halt is still low.
   assign w_accept  = commit_valid & ~r_halt & ~r_halt_pend;
   assign w_is_halt = (commit_pc == commit_pc_next) || (commit_inst == 32'h0000_0063) ||
                      (commit_inst == 32'h0000_006F) || (commit_inst == 32'hF000_2013);
   assign w_mem_any = |(commit_mem_rmask | commit_mem_wmask);
   assign w_rbyte   = {{8{commit_mem_rmask[3]}}, {8{commit_mem_rmask[2]}},
                       {8{commit_mem_rmask[1]}}, {8{commit_mem_rmask[0]}}};
   assign w_wbyte   = {{8{commit_mem_wmask[3]}}, {8{commit_mem_wmask[2]}},
                       {8{commit_mem_wmask[1]}}, {8{commit_mem_wmask[0]}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvfi_valid     <= 1'b0;
         rvfi_order     <= '0;
         r_order        <= '0;
         rvfi_inst      <= '0;
         rvfi_pc_rdata  <= '0;
         rvfi_pc_wdata  <= '0;
         rvfi_rs1_addr  <= '0;
         rvfi_rs2_addr  <= '0;
         rvfi_rd_addr   <= '0;
         rvfi_rs1_rdata <= '0;
         rvfi_rs2_rdata <= '0;
         rvfi_rd_wdata  <= '0;
         rvfi_mem_addr  <= '0;
         rvfi_mem_rdata <= '0;
         rvfi_mem_wdata <= '0;
         rvfi_mem_rmask <= '0;
         rvfi_mem_wmask <= '0;
      end else begin
         rvfi_valid <= w_accept;
         if (w_accept) begin
            rvfi_order     <= r_order;
            r_order        <= r_order + ORD_ONE;
            rvfi_inst      <= commit_inst;
            rvfi_pc_rdata  <= commit_pc;
            rvfi_pc_wdata  <= commit_pc_next;
            rvfi_rs1_addr  <= commit_rs1_addr;
            rvfi_rs2_addr  <= commit_rs2_addr;
            rvfi_rd_addr   <= commit_rd_addr;
            rvfi_rs1_rdata <= (commit_rs1_addr == 5'd0) ? 32'd0 : commit_rs1_rdata;
            rvfi_rs2_rdata <= (commit_rs2_addr == 5'd0) ? 32'd0 : commit_rs2_rdata;
            rvfi_rd_wdata  <= (commit_rd_addr == 5'd0) ? 32'd0 : commit_rd_wdata;
            rvfi_mem_addr  <= w_mem_any ? commit_mem_addr : 32'd0;
            rvfi_mem_rdata <= commit_mem_rdata & w_rbyte;
            rvfi_mem_wdata <= commit_mem_wdata & w_wbyte;
            rvfi_mem_rmask <= commit_mem_rmask;
            rvfi_mem_wmask <= commit_mem_wmask;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halt      <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_halt      <= r_halt | r_halt_pend;
         r_halt_pend <= w_accept & w_is_halt;
      end
   end

   assign rvfi_halt = r_halt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cyc   <= '0;
         r_ins   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cyc   <= w_cyc_nxt;
         r_ins   <= w_ins_nxt;
      end
   end

   // A start marker wins over counting, so a restart mid-segment clears instead of incrementing.
   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_cyc;
      w_ins_nxt   = r_ins;
      if (w_accept && commit_inst == START_INST) begin
         w_state_nxt = S_COUNT;
         w_cyc_nxt   = '0;
         w_ins_nxt   = '0;
      end else if (r_state == S_COUNT) begin
         w_cyc_nxt = (r_cyc == CNT_MAX) ? r_cyc : r_cyc + CNT_ONE;
         if (w_accept) begin
            w_ins_nxt = (r_ins == CNT_MAX) ? r_ins : r_ins + CNT_ONE;
            if (commit_inst == STOP_INST) w_state_nxt = S_DONE;
         end
      end
   end

   assign seg_cycles = r_cyc;
   assign seg_insts  = r_ins;
   assign seg_active = (r_state == S_COUNT);
   assign seg_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Drives two packer instances (default widths and ORDER_W=4/CNT_W=3) in lockstep and checks
// every cycle against a behavioural model of the retirement stream.
module tb_rvfi_commit_packer;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] START = 32'h0010_2013;
   localparam logic [31:0] STOP  = 32'h0020_2013;
   localparam logic [31:0] JAL   = 32'h0000_006F;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        cv;
   logic [31:0] inst, pc, pcn, rs1d, rs2d, rdd, ma, mr, mw;
   logic [4:0]  rs1a, rs2a, rda;
   logic [3:0]  rm, wm;

   logic        o_valid, o_halt, o_act, o_done;
   logic [63:0] o_order;
   logic [31:0] o_inst, o_pcr, o_pcw, o_rs1d, o_rs2d, o_rdd, o_ma, o_mr, o_mw;
   logic [4:0]  o_rs1a, o_rs2a, o_rda;
   logic [3:0]  o_rm, o_wm;
   logic [47:0] o_cyc, o_ins;

   logic        s_valid, s_halt, s_act, s_done;
   logic [3:0]  s_order;
   logic [31:0] s_inst, s_pcr, s_pcw, s_rs1d, s_rs2d, s_rdd, s_ma, s_mr, s_mw;
   logic [4:0]  s_rs1a, s_rs2a, s_rda;
   logic [3:0]  s_rm, s_wm;
   logic [2:0]  s_cyc, s_ins;

   rvfi_commit_packer u_dut (
      .clk(clk), .rst_n(rst_n), .commit_valid(cv), .commit_inst(inst), .commit_pc(pc),
      .commit_pc_next(pcn), .commit_rs1_addr(rs1a), .commit_rs2_addr(rs2a), .commit_rd_addr(rda),
      .commit_rs1_rdata(rs1d), .commit_rs2_rdata(rs2d), .commit_rd_wdata(rdd),
      .commit_mem_addr(ma), .commit_mem_rdata(mr), .commit_mem_wdata(mw),
      .commit_mem_rmask(rm), .commit_mem_wmask(wm),
      .rvfi_valid(o_valid), .rvfi_order(o_order), .rvfi_inst(o_inst), .rvfi_pc_rdata(o_pcr),
      .rvfi_pc_wdata(o_pcw), .rvfi_rs1_addr(o_rs1a), .rvfi_rs2_addr(o_rs2a), .rvfi_rd_addr(o_rda),
      .rvfi_rs1_rdata(o_rs1d), .rvfi_rs2_rdata(o_rs2d), .rvfi_rd_wdata(o_rdd),
      .rvfi_mem_addr(o_ma), .rvfi_mem_rdata(o_mr), .rvfi_mem_wdata(o_mw),
      .rvfi_mem_rmask(o_rm), .rvfi_mem_wmask(o_wm), .rvfi_halt(o_halt),
      .seg_cycles(o_cyc), .seg_insts(o_ins), .seg_active(o_act), .seg_done(o_done)
   );

   rvfi_commit_packer #(.ORDER_W(4), .CNT_W(3)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .commit_valid(cv), .commit_inst(inst), .commit_pc(pc),
      .commit_pc_next(pcn), .commit_rs1_addr(rs1a), .commit_rs2_addr(rs2a), .commit_rd_addr(rda),
      .commit_rs1_rdata(rs1d), .commit_rs2_rdata(rs2d), .commit_rd_wdata(rdd),
      .commit_mem_addr(ma), .commit_mem_rdata(mr), .commit_mem_wdata(mw),
      .commit_mem_rmask(rm), .commit_mem_wmask(wm),
      .rvfi_valid(s_valid), .rvfi_order(s_order), .rvfi_inst(s_inst), .rvfi_pc_rdata(s_pcr),
      .rvfi_pc_wdata(s_pcw), .rvfi_rs1_addr(s_rs1a), .rvfi_rs2_addr(s_rs2a), .rvfi_rd_addr(s_rda),
      .rvfi_rs1_rdata(s_rs1d), .rvfi_rs2_rdata(s_rs2d), .rvfi_rd_wdata(s_rdd),
      .rvfi_mem_addr(s_ma), .rvfi_mem_rdata(s_mr), .rvfi_mem_wdata(s_mw),
      .rvfi_mem_rmask(s_rm), .rvfi_mem_wmask(s_wm), .rvfi_halt(s_halt),
      .seg_cycles(s_cyc), .seg_insts(s_ins), .seg_active(s_act), .seg_done(s_done)
   );

   // Reference model: expected emitted record plus unbounded counters, saturated at compare time.
   typedef struct packed {
      logic [31:0] inst, pcr, pcw, rs1d, rs2d, rdd, ma, mr, mw;
      logic [4:0]  rs1a, rs2a, rda;
      logic [3:0]  rm, wm;
   } rec_t;

   rec_t        e_rec;
   logic        e_valid, m_halt, m_pend;
   logic [63:0] e_order, m_cnt;
   int          m_seg;             // 0 idle, 1 counting, 2 done
   longint unsigned m_cyc, m_ins;
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
      return r;
   endfunction

   function automatic logic [63:0] sat(input longint unsigned x, input int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 64'd1;
      return (x > mx) ? mx : x;
   endfunction

   task automatic model_reset();
      e_rec = '0; e_valid = 0; e_order = 0; m_cnt = 0;
      m_halt = 0; m_pend = 0; m_seg = 0; m_cyc = 0; m_ins = 0;
   endtask

   task automatic model_edge();
      bit acc, hrec;
      acc  = cv && !m_halt && !m_pend;
      hrec = acc && (pc == pcn || inst == 32'h63 || inst == JAL || inst == 32'hF000_2013);
      m_halt  = m_halt || m_pend;
      m_pend  = hrec;
      e_valid = acc;
      if (acc) begin
         e_order = m_cnt;
         m_cnt   = m_cnt + 1;
         e_rec.inst = inst; e_rec.pcr = pc; e_rec.pcw = pcn;
         e_rec.rs1a = rs1a; e_rec.rs2a = rs2a; e_rec.rda = rda;
         e_rec.rs1d = (rs1a == 0) ? 32'd0 : rs1d;
         e_rec.rs2d = (rs2a == 0) ? 32'd0 : rs2d;
         e_rec.rdd  = (rda == 0) ? 32'd0 : rdd;
         e_rec.ma   = (rm == 0 && wm == 0) ? 32'd0 : ma;
         e_rec.mr   = keep_bytes(mr, rm);
         e_rec.mw   = keep_bytes(mw, wm);
         e_rec.rm   = rm; e_rec.wm = wm;
      end
      if (acc && inst == START) begin
         m_seg = 1; m_cyc = 0; m_ins = 0;
      end else if (m_seg == 1) begin
         m_cyc++;
         if (acc) m_ins++;
         if (acc && inst == STOP) m_seg = 2;
      end
   endtask

   task automatic check_all();
      chk("valid", {63'd0, o_valid}, {63'd0, e_valid});
      chk("order", o_order, e_order);
      chk("inst_pc", {o_inst, o_pcr}, {e_rec.inst, e_rec.pcr});
      chk("pcw_rs1d", {o_pcw, o_rs1d}, {e_rec.pcw, e_rec.rs1d});
      chk("rs2d_rdd", {o_rs2d, o_rdd}, {e_rec.rs2d, e_rec.rdd});
      chk("maddr_mrd", {o_ma, o_mr}, {e_rec.ma, e_rec.mr});
      chk("mwd_masks", {9'd0, o_mw, o_rm, o_wm, o_rs1a, o_rs2a, o_rda},
          {9'd0, e_rec.mw, e_rec.rm, e_rec.wm, e_rec.rs1a, e_rec.rs2a, e_rec.rda});
      chk("halt", {63'd0, o_halt}, {63'd0, m_halt});
      chk("seg_state", {62'd0, o_act, o_done}, {62'd0, m_seg == 1, m_seg == 2});
      chk("seg_cycles", {16'd0, o_cyc}, sat(m_cyc, 48));
      chk("seg_insts", {16'd0, o_ins}, sat(m_ins, 48));
      chk("s_valid_halt", {62'd0, s_valid, s_halt}, {62'd0, e_valid, m_halt});
      chk("s_order", {60'd0, s_order}, e_order & 64'hF);
      chk("s_seg_cycles", {61'd0, s_cyc}, sat(m_cyc, 3));
      chk("s_seg_insts", {61'd0, s_ins}, sat(m_ins, 3));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_fields();
      rs1a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs2a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rda  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1d = $urandom; rs2d = $urandom; rdd = $urandom;
      ma = $urandom; mr = $urandom; mw = $urandom;
      rm = 4'($urandom); wm = 4'($urandom);
   endtask

   task automatic go(input bit v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] pn);
      rand_fields();
      cv = v; inst = i; pc = p; pcn = pn;
      cyc();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) go(1'b0, $urandom, $urandom, $urandom);
   endtask

   // Reset is asserted away from the clock edge and outputs are checked before the next edge.
   task automatic do_reset();
      rst_n = 1'b0;
      cv = 1'b0;
      #2;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      cv = 0; inst = NOP; pc = 0; pcn = 4;
      rand_fields();
      #1;
      do_reset();

      for (int k = 0; k < 3; k++) go(1'b1, NOP, 32'(4 * k), 32'(4 * k + 4));
      chk("basic_last_order", o_order, 64'd2);
      idle(1);

      rand_fields();
      cv = 1; inst = NOP; pc = 32'h100; pcn = 32'h104;
      rda = 0; rdd = 32'hDEAD_BEEF; wm = 4'b0011; rm = 4'b0000; mw = 32'hAABB_CCDD;
      cyc();
      chk("scrub_rd", {32'd0, o_rdd}, 64'd0);
      chk("scrub_wdata", {32'd0, o_mw}, 64'h0000_CCDD);
      rand_fields();
      cv = 1; inst = NOP; pc = 32'h104; pcn = 32'h108; rm = 0; wm = 0; ma = 32'h1234_5678;
      cyc();
      chk("scrub_addr", {32'd0, o_ma}, 64'd0);

      do_reset();
      go(1'b1, NOP, 32'h0, 32'h4);
      go(1'b1, JAL, 32'h4, 32'h40);
      go(1'b1, NOP, 32'h40, 32'h44);
      go(1'b1, NOP, 32'h44, 32'h48);
      idle(2);
      chk("halt_jal", {63'd0, o_halt}, 64'd1);
      chk("halt_order_frozen", o_order, 64'd1);
      do_reset();
      go(1'b1, NOP, 32'h80, 32'h80);
      go(1'b1, NOP, 32'h84, 32'h88);
      idle(1);
      chk("halt_pc_loop", {63'd0, o_halt}, 64'd1);

      do_reset();
      go(1'b1, START, 32'h0, 32'h4);
      for (int k = 0; k < 5; k++) begin
         go(1'b1, NOP, 32'(8 + 4 * k), 32'(12 + 4 * k));
         idle(1);
      end
      go(1'b1, STOP, 32'h40, 32'h44);
      chk("seg_insts6", {16'd0, o_ins}, 64'd6);
      chk("seg_cycles11", {16'd0, o_cyc}, 64'd11);
      chk("seg_done", {63'd0, o_done}, 64'd1);
      idle(2);
      go(1'b1, STOP, 32'h50, 32'h54);
      go(1'b1, START, 32'h54, 32'h58);
      chk("seg_restart", {o_cyc, o_ins[15:0]}, 64'd0);

      do_reset();
      for (int k = 0; k < 18; k++) go(1'b1, NOP, 32'(4 * k), 32'(4 * k + 4));
      chk("wrap_order_s", {60'd0, s_order}, 64'd1);
      go(1'b1, START, 32'h100, 32'h104);
      for (int k = 0; k < 10; k++) go(1'b1, NOP, 32'(4 * k), 32'(4 * k + 4));
      chk("sat_insts_s", {61'd0, s_ins}, 64'd7);
      chk("insts_wide", {16'd0, o_ins}, 64'd10);

      do_reset();
      go(1'b1, START, 32'h0, 32'h4);
      go(1'b1, NOP, 32'h4, 32'h8);
      do_reset();
      go(1'b1, NOP, 32'h8, 32'hC);
      chk("post_rst_order", o_order, 64'd0);
      go(1'b1, JAL, 32'hC, 32'h10);
      idle(2);
      do_reset();
      go(1'b1, NOP, 32'h10, 32'h14);
      chk("post_halt_rst", {o_order[62:0], o_halt}, 64'd0);

      for (int n = 0; n < 2500; n++) begin
         int r;
         logic [31:0] ri, rp;
         if ($urandom_range(0, 99) < 4) begin
            do_reset();
         end else begin
            r  = $urandom_range(0, 63);
            ri = (r == 0) ? START : (r == 1) ? STOP : (r == 2) ? JAL :
                 (r == 3) ? 32'h63 : (r == 4) ? 32'hF000_2013 : (r < 20) ? NOP : $urandom;
            rp = $urandom;
            go($urandom_range(0, 9) < 7, ri, rp, ($urandom_range(0, 39) == 0) ? rp : rp + 4);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rvfi_commit_packer.md
# rvfi_commit_packer

Core-side producer for the RVFI retirement interface. It registers one retirement record per cycle from the core's commit stage and drives the `mon_itf` signal set consumed by the bench monitor. It assigns the monotonically increasing `order` and scrubs don't-care fields to zero. It also detects halt instructions and raises `halt`, and keeps marker-delimited segment cycle/instruction counters for in-RTL IPC readout.

## Interface
- `ORDER_W`, default 64: width of `rvfi_order`.
- `CNT_W`, default 48: width of the segment counters, which saturate.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `commit_valid`  in  1  — the core retires one instruction this cycle.
- `commit_inst`, `commit_pc`, `commit_pc_next`  in  32 each  — instruction word, its PC, next PC.
- `commit_rs1_addr`, `commit_rs2_addr`, `commit_rd_addr`  in  5 each.
- `commit_rs1_rdata`, `commit_rs2_rdata`, `commit_rd_wdata`  in  32 each.
- `commit_mem_addr`, `commit_mem_rdata`, `commit_mem_wdata`  in  32 each.
- `commit_mem_rmask`, `commit_mem_wmask`  in  4 each.
- `rvfi_valid`  out  1  — one-cycle strobe per emitted record.
- `rvfi_order`  out  ORDER_W  — record index, 0-based.
- `rvfi_inst`, `rvfi_pc_rdata`, `rvfi_pc_wdata`  out  32 each.
- `rvfi_rs1_addr`, `rvfi_rs2_addr`, `rvfi_rd_addr`  out  5 each.
- `rvfi_rs1_rdata`, `rvfi_rs2_rdata`, `rvfi_rd_wdata`  out  32 each.
- `rvfi_mem_addr`, `rvfi_mem_rdata`, `rvfi_mem_wdata`  out  32 each.
- `rvfi_mem_rmask`, `rvfi_mem_wmask`  out  4 each.
- `rvfi_halt`  out  1  — sticky; set after a halt record is emitted.
- `seg_cycles`, `seg_insts`  out  CNT_W each  — segment counters.
- `seg_active`, `seg_done`  out  1 each  — segment FSM status.

## Operation
- **Accept condition.** A record is accepted when `commit_valid=1` and `rvfi_halt=0`. After halt, commits are ignored: no strobe, no counter update.
- **Registering.** Every output is registered. On accept, all `rvfi_*` fields load from the corresponding `commit_*` inputs.
- **Order.** `rvfi_order` takes the internal count, then the count increments. The count wraps modulo 2^ORDER_W.
- **Scrubbing.** Each of the following is forced to 0 at load time:
  - `rs1_rdata` if `rs1_addr=0`.
  - `rs2_rdata` if `rs2_addr=0`.
  - `rd_wdata` if `rd_addr=0`.
  - Each byte i of `mem_rdata` whose `rmask[i]=0`.
  - Each byte i of `mem_wdata` whose `wmask[i]=0`.
  - `mem_addr` if both masks are 0.
- **Hold between records.** When no record is accepted, `rvfi_valid=0` and the data fields hold their last values.
- **Halt condition.** An accepted record is a halt record if any of these holds:
  - `commit_pc == commit_pc_next`;
  - inst = 0x00000063;
  - inst = 0x0000006F;
  - inst = 0xF0002013.
- **Halt effect.** A halt record is still emitted normally. `rvfi_halt` then sets and stays set until reset.
- **Segment FSM states.**
  - IDLE: `seg_active=0`, `seg_done=0`.
  - COUNT: `seg_active=1`.
  - DONE: `seg_done=1`, counters frozen.
- **Segment FSM transitions.**
  - Accepted inst 0x00102013 in any state → COUNT, with both counters cleared to 0. The start marker is not counted.
  - In COUNT, every clock edge adds 1 to `seg_cycles`.
  - In COUNT, every accepted record adds 1 to `seg_insts`. The stop marker is included.
  - Accepted inst 0x00202013 in COUNT → DONE.
  - Stop marker in IDLE or DONE is ignored.
- **Saturation.** Both counters saturate at 2^CNT_W−1 and never wrap.
- **Halt during a segment.** Halt in COUNT freezes `seg_insts`, since no further records are accepted. `seg_cycles` keeps running.

## Timing
- **Reset values.** While `rst_n=0`, asynchronously: every output is 0, the order count is 0, and the FSM is IDLE. Reset mid-segment or mid-halt discards all state. The first record after `rst_n` rises gets order 0.
- **Latency: 1 cycle.** A commit sampled at edge N appears on `rvfi_*` with `rvfi_valid=1` from edge N until edge N+1.
- **Back-to-back.** Commits on consecutive cycles produce consecutive valid strobes with consecutive order values, with no bubbles.
- **Halt timing.** `rvfi_halt` rises at edge N+1 for a halt record accepted at edge N, i.e. one cycle after that record's strobe. A commit at edge N+1 is dropped.
- **Segment status timing.** `seg_active` and `seg_done` change at the same edge that the triggering marker's record is registered.
- **Segment counter timing.** `seg_cycles` counts edges strictly after the start edge, up to and including the stop edge.
- No backpressure: the monitor side always accepts.

## Test plan
- **Reset and basic stream.** Reset, then 3 back-to-back commits with PC 0x0, 0x4, 0x8 → valid high for 3 cycles; order 0, 1, 2; pc_wdata echoed; no halt.
- **Scrubbing.** Commit with rd_addr=0, rd_wdata=0xDEADBEEF, wmask=0b0011, wdata=0xAABBCCDD → `rvfi_rd_wdata=0`, `rvfi_mem_wdata=0x0000CCDD`. Second commit with masks 0 → `rvfi_mem_addr=0`.
- **Halt.** Commit inst 0x0000006F, then 2 more commits → the jal record is emitted; halt=1 on the next cycle; no further valid; order frozen. Repeat using the pc==pc_next trigger.
- **Segment.** Start marker, 5 commits spaced 2 cycles apart, stop marker → `seg_insts=6`, `seg_done=1`, `seg_cycles` equals the edge count from start to stop. A later stop marker has no effect; a new start marker clears to 0.
- **Wrap and saturation.** ORDER_W=4: 18 commits → order sequence 0…15, 0, 1. CNT_W=3: 10 commits inside a segment → `seg_insts=7`.
- **Mid-operation reset.** Drop `rst_n` asynchronously (mid-cycle) during COUNT and after halt → all outputs 0 immediately; the next commit yields order 0 with halt=0.
